// File: rtl/bg_render_pkg.sv
// Shared types and constants for the background render path.
package bg_render_pkg;

    // Render sequencing states: wait for a request, wait for a frame start, render.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2
    } bg_state_t;

    // Cycles from a DrawX/DrawY/de sample to the matching colour and de_out.
    localparam int PIPE_LAT = 3;

    // Default source image geometry (QVGA upscaled to VGA).
    localparam int IMG_W_DEFAULT = 320;
    localparam int IMG_H_DEFAULT = 240;

    // Packed {red, green, blue}, 4 bits each.
    typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/bg_addr_gen.sv
// Raster-to-ROM address generation for the background image.
// The row base is built by accumulation so no multiplier is needed.
module bg_addr_gen
    import bg_render_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEFAULT,
    parameter int IMG_H       = IMG_H_DEFAULT,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              de,
    input  logic              render_en,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              in_img
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [10:0]       IMG_W_L  = 11'(IMG_W);
    localparam logic [10:0]       IMG_H_L  = 11'(IMG_H);
    // Selects the DrawY bits that count repeats of the same source row.
    localparam logic [9:0]        SUB_MASK = 10'((1 << SCALE_SHIFT) - 1);

    logic [9:0]        col;
    logic [9:0]        src_row;
    logic              frame_start;
    logic              new_src_row;
    logic              col_ok;
    logic              row_ok;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] row_base_d;

    assign col         = DrawX >> SCALE_SHIFT;
    assign src_row     = DrawY >> SCALE_SHIFT;
    assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign new_src_row = (DrawX == 10'd0) && (DrawY != 10'd0)
                       && ((DrawY & SUB_MASK) == 10'd0);
    assign col_ok      = {1'b0, col} < IMG_W_L;
    assign row_ok      = {1'b0, src_row} < IMG_H_L;

    // Row base clears at frame start and steps by one image row at each new
    // source row; it freezes once the raster has left the image vertically.
    always_comb begin
        row_base_d = row_base_q;
        if (frame_start) begin
            row_base_d = '0;
        end else if (new_src_row && row_ok) begin
            row_base_d = row_base_q + ROW_STEP;
        end
    end

    // Row base register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            row_base_q <= '0;
        end else begin
            row_base_q <= row_base_d;
        end
    end

    // The updated base is used for the current pixel so the first pixel of a
    // new source row already addresses that row.
    assign pix_addr = row_base_d + ADDR_W'(col);
    assign in_img   = col_ok && row_ok && de && render_en;

endmodule

// File: rtl/bg_render_ctrl.sv
// Background render controller: frame-aligned enable FSM, ROM address
// stage, palette interface and registered RGB output, 3-cycle latency.
module bg_render_ctrl
    import bg_render_pkg::*;
#(
    parameter int     IMG_W       = IMG_W_DEFAULT,
    parameter int     IMG_H       = IMG_H_DEFAULT,
    parameter int     SCALE_SHIFT = 1,
    parameter int     ADDR_W      = 17,
    parameter rgb12_t BORDER_RGB  = 12'h000
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              de,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic [4:0]        pal_index,
    input  logic [11:0]       pal_rgb,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              de_out,
    output logic              active
);

    bg_state_t             state_q;
    bg_state_t             state_d;
    logic                  active_q;
    logic                  active_d;
    logic                  frame_start;

    logic [ADDR_W-1:0]     pix_addr;
    logic                  in_img;

    logic [ADDR_W-1:0]     rom_addr_q;
    logic [ADDR_W-1:0]     rom_addr_d;
    logic                  s1_img_q;
    logic                  s1_img_d;
    logic                  s2_img_q;
    logic                  s2_img_d;
    rgb12_t                rgb_q;
    rgb12_t                rgb_d;
    logic [PIPE_LAT-1:0]   de_pipe_q;
    logic [PIPE_LAT-1:0]   de_pipe_d;

    assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

    // Next state: enable changes only take effect at a frame start, so a
    // frame is either rendered completely or not at all.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (frame_start) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (frame_start && !en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        active_d = (state_d == ACTIVE);
    end

    // State and active flag registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    // The in-image decision uses the next state, so pixel (0,0) of the first
    // rendered frame is already drawn and the first pixel after disabling is not.
    bg_addr_gen #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .SCALE_SHIFT (SCALE_SHIFT),
        .ADDR_W      (ADDR_W)
    ) u_addr_gen (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .de        (de),
        .render_en (state_d == ACTIVE),
        .pix_addr  (pix_addr),
        .in_img    (in_img)
    );

    // Pipeline next values: address holds outside the image, flags shift,
    // colour stage picks the palette colour or the border.
    always_comb begin
        rom_addr_d = in_img ? pix_addr : rom_addr_q;
        s1_img_d   = in_img;
        s2_img_d   = s1_img_q;
        rgb_d      = s2_img_q ? rgb12_t'(pal_rgb) : BORDER_RGB;
        de_pipe_d  = {de_pipe_q[PIPE_LAT-2:0], de};
    end

    // Pipeline registers; stage 2 data lives in the ROM's own output register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            s1_img_q   <= 1'b0;
            s2_img_q   <= 1'b0;
            rgb_q      <= BORDER_RGB;
            de_pipe_q  <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            s1_img_q   <= s1_img_d;
            s2_img_q   <= s2_img_d;
            rgb_q      <= rgb_d;
            de_pipe_q  <= de_pipe_d;
        end
    end

    // Index is gated by the stage-2 flag so it reads 0 from reset and
    // whenever the ROM word belongs to a border pixel.
    assign pal_index = s2_img_q ? rom_data : 5'd0;
    assign rom_addr  = rom_addr_q;
    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign de_out    = de_pipe_q[PIPE_LAT-1];
    assign active    = active_q;

endmodule

// File: tb/tb_bg_render_ctrl.sv
// Testbench for bg_render_ctrl: drives a sparse raster (a few columns per
// row plus one blanking pixel) into a 320-wide and a 200-wide instance with
// ROM and palette models, and checks address, colour and de_out through a
// cycle-stamped scoreboard.
module tb_bg_render_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        en;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        de;

    logic [16:0] rom_addr,  rom_addr2;
    logic [4:0]  rom_data,  rom_data2;
    logic [4:0]  pal_index, pal_index2;
    logic [11:0] pal_rgb,   pal_rgb2;
    logic [3:0]  red, green, blue;
    logic [3:0]  red2, green2, blue2;
    logic        de_out, de_out2;
    logic        active, active2;

    always #5 Clk = ~Clk;

    bg_render_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .en(en), .DrawX(DrawX), .DrawY(DrawY), .de(de),
        .rom_addr(rom_addr), .rom_data(rom_data), .pal_index(pal_index), .pal_rgb(pal_rgb),
        .red(red), .green(green), .blue(blue), .de_out(de_out), .active(active)
    );

    bg_render_ctrl #(.IMG_W(200)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .en(en), .DrawX(DrawX), .DrawY(DrawY), .de(de),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .pal_index(pal_index2), .pal_rgb(pal_rgb2),
        .red(red2), .green(green2), .blue(blue2), .de_out(de_out2), .active(active2)
    );

    // ROM content: address 8050 = (100,50) returns index 5.
    function automatic logic [4:0] rom_func(input logic [16:0] a);
        return a[4:0] ^ 5'd23;
    endfunction

    // Palette: entry 5 is 12'hC2C; no entry equals the black border.
    function automatic logic [11:0] pal_func(input logic [4:0] i);
        if (i == 5'd5) return 12'hC2C;
        return {i[3:0], 3'b000, i[4], ~i[3:0]};
    endfunction

    always @(posedge Clk) rom_data  <= rom_func(rom_addr);
    always @(posedge Clk) rom_data2 <= rom_func(rom_addr2);
    assign pal_rgb  = pal_func(pal_index);
    assign pal_rgb2 = pal_func(pal_index2);

    typedef struct {
        int          due;
        logic [16:0] a1;
        logic [16:0] a2;
    } aexp_t;

    typedef struct {
        int          due;
        logic [11:0] c1;
        logic [11:0] c2;
        logic        d;
    } pexp_t;

    aexp_t       aq[$];
    pexp_t       pq[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [16:0] last1 = '0;
    logic [16:0] last2 = '0;
    logic        en_cur = 1'b0;
    int          cols[8] = '{0, 1, 2, 3, 100, 399, 400, 639};

    always @(posedge Clk) cyc <= cyc + 1;

    // Scoreboard: pops entries whose due cycle has arrived and compares.
    always @(negedge Clk) begin : monitor
        aexp_t ae;
        pexp_t pe;
        if (Reset_n === 1'b1) begin
            if (aq.size() > 0 && aq[0].due == cyc) begin
                ae = aq.pop_front();
                checks++;
                if (rom_addr !== ae.a1) begin
                    errors++;
                    $display("FAIL rom_addr cyc=%0d got %0d exp %0d", cyc, rom_addr, ae.a1);
                end
                checks++;
                if (rom_addr2 !== ae.a2) begin
                    errors++;
                    $display("FAIL rom_addr_w200 cyc=%0d got %0d exp %0d", cyc, rom_addr2, ae.a2);
                end
            end
            if (pq.size() > 0 && pq[0].due == cyc) begin
                pe = pq.pop_front();
                checks++;
                if ({red, green, blue} !== pe.c1) begin
                    errors++;
                    $display("FAIL rgb cyc=%0d got %h exp %h", cyc, {red, green, blue}, pe.c1);
                end
                checks++;
                if ({red2, green2, blue2} !== pe.c2) begin
                    errors++;
                    $display("FAIL rgb_w200 cyc=%0d got %h exp %h", cyc, {red2, green2, blue2}, pe.c2);
                end
                checks++;
                if (de_out !== pe.d || de_out2 !== pe.d) begin
                    errors++;
                    $display("FAIL de_out cyc=%0d got %b/%b exp %b", cyc, de_out, de_out2, pe.d);
                end
            end
        end
    end

    // Drive one pixel on the falling edge and record what it must produce.
    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic d,
                        input logic e, input bit act);
        aexp_t ae;
        pexp_t pe;
        int    sx;
        int    sy;
        bit    r1;
        bit    r2;
        @(negedge Clk);
        DrawX = x;
        DrawY = y;
        de    = d;
        en    = e;
        sx = int'(x) >> 1;
        sy = int'(y) >> 1;
        r1 = act && d && (sx < 320) && (sy < 240);
        r2 = act && d && (sx < 200) && (sy < 240);
        if (r1) last1 = 17'(sy * 320 + sx);
        if (r2) last2 = 17'(sy * 200 + sx);
        ae.due = cyc + 1;
        ae.a1  = last1;
        ae.a2  = last2;
        aq.push_back(ae);
        pe.due = cyc + 3;
        pe.c1  = r1 ? pal_func(rom_func(last1)) : 12'h000;
        pe.c2  = r2 ? pal_func(rom_func(last2)) : 12'h000;
        pe.d   = d;
        pq.push_back(pe);
    endtask

    // Raster rows y0..y1; act is whether the frame is expected to render.
    task automatic run_rows(input int y0, input int y1, input bit act, input int drop_row);
        for (int y = y0; y <= y1; y++) begin
            for (int c = 0; c < 8; c++) begin
                if (y == drop_row && c == 0) en_cur = 1'b0;
                step(10'(cols[c]), 10'(y), 1'b1, en_cur, act);
                if (y == 0 && c == 0) begin
                    @(posedge Clk);
                    #1;
                    checks++;
                    if (active !== act || active2 !== act) begin
                        errors++;
                        $display("FAIL active_after_frame_start got %b/%b exp %b", active, active2, act);
                    end
                end
            end
            step(10'd700, 10'(y), 1'b0, en_cur, act);
        end
        $display("rows %0d..%0d act=%0d en=%0b checks=%0d", y0, y1, act, en_cur, checks);
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        en_cur  = 1'b1;
        en      = 1'b1;
        DrawX   = 10'd700;
        DrawY   = 10'd500;
        de      = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (rom_addr !== 17'd0 || rom_addr2 !== 17'd0) begin
            errors++;
            $display("FAIL reset_rom_addr got %0d/%0d exp 0", rom_addr, rom_addr2);
        end
        checks++;
        if (pal_index !== 5'd0) begin
            errors++;
            $display("FAIL reset_pal_index got %0d exp 0", pal_index);
        end
        checks++;
        if ({red, green, blue} !== 12'h000 || de_out !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rgb=%h de_out=%b active=%b exp 000/0/0",
                     {red, green, blue}, de_out, active);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) step(10'd700, 10'd500, 1'b0, en_cur, 1'b0);
        @(posedge Clk);
        #1;
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL active_before_frame_start got %b exp 0", active);
        end
        $display("test_reset done");
    endtask

    // First full frame: addresses, (100,50) colour, last pixel 76799.
    task automatic test_render_frame;
        run_rows(0, 479, 1'b1, -1);
        $display("test_render_frame done");
    endtask

    // en dropped at row 200: frame completes, next frame is border only.
    task automatic test_disable;
        en_cur = 1'b1;
        run_rows(0, 479, 1'b1, 200);
        run_rows(0, 479, 1'b0, -1);
        $display("test_disable done");
    endtask

    // en raised on the frame-start pixel from IDLE only arms; next frame renders.
    task automatic test_en_at_frame_start;
        en_cur = 1'b1;
        run_rows(0, 479, 1'b0, -1);
        run_rows(0, 479, 1'b1, -1);
        $display("test_en_at_frame_start done");
    endtask

    task automatic test_reset_mid_frame;
        en_cur = 1'b1;
        run_rows(0, 99, 1'b1, -1);
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (rom_addr !== 17'd0 || pal_index !== 5'd0 || {red, green, blue} !== 12'h000
            || de_out !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset got addr=%0d idx=%0d rgb=%h de_out=%b active=%b exp 0/0/000/0/0",
                     rom_addr, pal_index, {red, green, blue}, de_out, active);
        end
        aq.delete();
        pq.delete();
        last1 = '0;
        last2 = '0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        run_rows(100, 479, 1'b0, -1);
        run_rows(0, 479, 1'b1, -1);
        $display("test_reset_mid_frame done");
    endtask

    task automatic test_drain;
        repeat (4) step(10'd700, 10'd0, 1'b0, en_cur, 1'b0);
        repeat (4) @(negedge Clk);
        #1;
        checks++;
        if (aq.size() != 0 || pq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d pending exp 0/0", aq.size(), pq.size());
        end
    endtask

    initial begin
        test_reset();
        test_render_frame();
        test_disable();
        test_en_at_frame_start();
        test_reset_mid_frame();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
